// File: rtl/tm1637_responder.sv
// TM1637-style responder: receives start/byte/ACK/stop frames on CLK/DIO and
// decodes data, address and display-control commands into digit registers.
module tm1637_responder #(
    parameter int DIGITS      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_en,
    output logic                  sda_out,
    output logic [8*DIGITS-1:0]   digits,
    output logic                  display_on,
    output logic [2:0]            brightness,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  cmd_error
);

    typedef enum logic [1:0] {IDLE, RX, ACK_WAIT, ACK_HOLD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s, scl_q, sda_q;
    logic                   scl_rise, scl_fall, start_cond, stop_cond;
    logic [6:0]             rx_bits;
    logic [7:0]             rx_byte;
    logic [2:0]             bit_cnt;
    logic [3:0]             byte_idx;
    logic [2:0]             ptr;
    logic                   fixed_mode;
    logic                   addr_txn;

    assign scl_s   = scl_sync[SYNC_STAGES-1];
    assign sda_s   = sda_sync[SYNC_STAGES-1];
    assign sda_out = 1'b0;

    // Start/stop need scl high in both samples, so an sda change that lands
    // together with a scl edge is treated as an ordinary data transition.
    assign scl_rise   = scl_s & ~scl_q;
    assign scl_fall   = ~scl_s & scl_q;
    assign start_cond = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_cond  = scl_s & scl_q & ~sda_q & sda_s;
    assign rx_byte    = {sda_s, rx_bits};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            rx_bits    <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            ptr        <= '0;
            fixed_mode <= 1'b0;
            addr_txn   <= 1'b0;
            sda_en     <= 1'b0;
            digits     <= '0;
            display_on <= 1'b0;
            brightness <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            cmd_error  <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            byte_valid <= 1'b0;

            if (start_cond) begin
                state    <= RX;
                bit_cnt  <= '0;
                byte_idx <= '0;
                sda_en   <= 1'b0;
            end else if (stop_cond) begin
                state  <= IDLE;
                sda_en <= 1'b0;
            end else begin
                case (state)
                    RX: if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            byte_data  <= rx_byte;
                            byte_valid <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= ACK_WAIT;
                            if (byte_idx == 4'd0) begin
                                case (rx_byte[7:6])
                                    2'b01: begin
                                        fixed_mode <= rx_byte[2];
                                        addr_txn   <= 1'b0;
                                        if (rx_byte[1:0] != 2'b00) cmd_error <= 1'b1;
                                    end
                                    2'b11: begin
                                        ptr      <= rx_byte[2:0];
                                        addr_txn <= 1'b1;
                                    end
                                    2'b10: begin
                                        display_on <= rx_byte[3];
                                        brightness <= rx_byte[2:0];
                                        addr_txn   <= 1'b0;
                                    end
                                    default: begin
                                        cmd_error <= 1'b1;
                                        addr_txn  <= 1'b0;
                                    end
                                endcase
                            end else if (addr_txn) begin
                                if (int'(ptr) < DIGITS) begin
                                    for (int n = 0; n < DIGITS; n++) begin
                                        if (ptr == 3'(n)) digits[8*n +: 8] <= rx_byte;
                                    end
                                end else begin
                                    cmd_error <= 1'b1;
                                end
                                // Auto-increment saturates at the last address, no wrap.
                                if (!fixed_mode && ptr != 3'd7) ptr <= ptr + 3'd1;
                            end
                        end else begin
                            rx_bits <= {sda_s, rx_bits[6:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ACK_WAIT: if (scl_fall) begin
                        sda_en <= 1'b1;
                        state  <= ACK_HOLD;
                    end
                    ACK_HOLD: if (scl_fall) begin
                        sda_en  <= 1'b0;
                        bit_cnt <= '0;
                        if (byte_idx != 4'd15) byte_idx <= byte_idx + 4'd1;
                        state   <= RX;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1637_responder.sv
// Bench for tm1637_responder: a bit-level bus master, a transaction-level
// reference model of the display registers and a byte_valid scoreboard.
module tb_tm1637_responder;

    localparam int DIGITS = 6;
    localparam int H      = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                scl;
    logic                sda_m;
    logic                sda_line;
    logic                sda_en, sda_out;
    logic [8*DIGITS-1:0] digits;
    logic                display_on;
    logic [2:0]          brightness;
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                cmd_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] txn_q[$];
    logic [7:0] mon_exp;

    logic [7:0] m_dig[8];
    logic       m_on;
    logic [2:0] m_bright;
    logic       m_err;
    logic       m_fixed;
    int         m_ptr;

    always #5 clk = ~clk;

    // Wired-AND open-drain DIO.
    assign sda_line = sda_m & (sda_en ? sda_out : 1'b1);

    tm1637_responder #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line),
        .sda_en(sda_en), .sda_out(sda_out), .digits(digits),
        .display_on(display_on), .brightness(brightness),
        .byte_valid(byte_valid), .byte_data(byte_data), .cmd_error(cmd_error)
    );

    // Scoreboard: every byte_valid pulse must match the next expected byte.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL byte_valid_unexpected: got byte_data=%h, expected no pulse", byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (byte_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL byte_data: got %h, expected %h", byte_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_on = 0; m_bright = 0; m_err = 0; m_fixed = 0; m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic model_txn();
        logic [7:0] b0;
        foreach (txn_q[i]) exp_q.push_back(txn_q[i]);
        b0 = txn_q[0];
        case (b0[7:6])
            2'b01: begin
                m_fixed = b0[2];
                if (b0[1:0] != 2'b00) m_err = 1;
            end
            2'b11: begin
                m_ptr = int'(b0[2:0]);
                for (int i = 1; i < txn_q.size(); i++) begin
                    if (m_ptr < DIGITS) m_dig[m_ptr] = txn_q[i];
                    else m_err = 1;
                    if (!m_fixed && m_ptr < 7) m_ptr++;
                end
            end
            2'b10: begin
                m_on = b0[3];
                m_bright = b0[2:0];
            end
            default: m_err = 1;
        endcase
    endtask

    function automatic logic [8*DIGITS-1:0] m_digits();
        for (int n = 0; n < DIGITS; n++) m_digits[8*n +: 8] = m_dig[n];
    endfunction

    // ---------------- bus driver ----------------
    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; scl = 1; sda_m = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        wait_h();
        model_reset();
    endtask

    task automatic bus_start();
        scl = 1; sda_m = 1; wait_h();
        sda_m = 0; wait_h(); wait_h();
    endtask

    task automatic bus_stop();
        scl = 0; wait_h();
        sda_m = 0; wait_h();
        scl = 1; wait_h();
        sda_m = 1; wait_h(); wait_h();
    endtask

    task automatic send_bit(input logic b);
        scl = 0; wait_h();
        sda_m = b; wait_h();
        scl = 1; wait_h(); wait_h();
    endtask

    // Ninth clock; exp_ack says whether the responder should pull DIO low.
    task automatic clock_ack(input logic exp_ack);
        n_cmp++;
        if (sda_en !== 1'b0) begin
            n_err++; $display("FAIL ack_early: sda_en=%b, expected 0 before 8th fall", sda_en);
        end
        scl = 0; wait_h();
        sda_m = 1; wait_h();
        n_cmp++;
        if (sda_en !== exp_ack) begin
            n_err++; $display("FAIL ack_start: sda_en=%b, expected %b", sda_en, exp_ack);
        end
        scl = 1; wait_h();
        n_cmp++;
        if (sda_line !== !exp_ack) begin
            n_err++; $display("FAIL ack_9th_clock: dio=%b, expected %b", sda_line, !exp_ack);
        end
        scl = 0; wait_h();
        n_cmp++;
        if (sda_en !== 1'b0) begin
            n_err++; $display("FAIL ack_release: sda_en=%b, expected 0 after 9th fall", sda_en);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        clock_ack(exp_ack);
    endtask

    task automatic run_txn();
        model_txn();
        bus_start();
        foreach (txn_q[i]) send_byte(txn_q[i], 1'b1);
        bus_stop();
        txn_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp += 9;
        if (digits !== '0)       begin n_err++; $display("FAIL reset_digits: got %h, expected 0", digits); end
        if (display_on !== 1'b0) begin n_err++; $display("FAIL reset_display_on: got %b, expected 0", display_on); end
        if (brightness !== 3'd0) begin n_err++; $display("FAIL reset_brightness: got %0d, expected 0", brightness); end
        if (byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_byte_valid: got %b, expected 0", byte_valid); end
        if (byte_data !== 8'h00) begin n_err++; $display("FAIL reset_byte_data: got %h, expected 0", byte_data); end
        if (cmd_error !== 1'b0)  begin n_err++; $display("FAIL reset_cmd_error: got %b, expected 0", cmd_error); end
        if (sda_en !== 1'b0)     begin n_err++; $display("FAIL reset_sda_en: got %b, expected 0", sda_en); end
        if (sda_out !== 1'b0)    begin n_err++; $display("FAIL reset_sda_out: got %b, expected 0", sda_out); end
        if (sda_line !== 1'b1)   begin n_err++; $display("FAIL reset_dio: got %b, expected 1", sda_line); end
    endtask

    task automatic test_auto_write();
        txn_q = '{8'h40}; run_txn();
        txn_q = '{8'hC0, 8'h06, 8'h5B, 8'h4F, 8'h66}; run_txn();
        n_cmp += 4;
        if (digits !== m_digits()) begin n_err++; $display("FAIL auto_digits: got %h, expected %h", digits, m_digits()); end
        if (digits !== 48'h0000_664F_5B06) begin n_err++; $display("FAIL auto_digits_plan: got %h, expected 0000664f5b06", digits); end
        if (cmd_error !== 1'b0) begin n_err++; $display("FAIL auto_cmd_error: got %b, expected 0", cmd_error); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL auto_pulses: %0d bytes without byte_valid, expected 0", exp_q.size()); end
    endtask

    task automatic test_display_ctrl();
        txn_q = '{8'h8F}; run_txn();
        n_cmp += 2;
        if (display_on !== 1'b1) begin n_err++; $display("FAIL disp_on_8f: got %b, expected 1", display_on); end
        if (brightness !== 3'd7) begin n_err++; $display("FAIL disp_bright_8f: got %0d, expected 7", brightness); end
        txn_q = '{8'h80}; run_txn();
        n_cmp += 2;
        if (display_on !== 1'b0) begin n_err++; $display("FAIL disp_on_80: got %b, expected 0", display_on); end
        if (brightness !== 3'd0) begin n_err++; $display("FAIL disp_bright_80: got %0d, expected 0", brightness); end
    endtask

    task automatic test_fixed_mode();
        txn_q = '{8'h44}; run_txn();
        txn_q = '{8'hC5, 8'h3F, 8'h06}; run_txn();
        n_cmp += 2;
        if (digits !== m_digits()) begin n_err++; $display("FAIL fixed_digits: got %h, expected %h", digits, m_digits()); end
        if (digits[47:40] !== 8'h06) begin n_err++; $display("FAIL fixed_digit5: got %h, expected 06", digits[47:40]); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int kind, p, n;
        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                b = 8'h40; b[2] = 1'($urandom_range(0, 1));
                txn_q.push_back(b);
                n = $urandom_range(0, 1);
                for (int i = 0; i < n; i++) txn_q.push_back(8'($urandom_range(0, 255)));
            end else if (kind == 1) begin
                p = $urandom_range(0, DIGITS - 1);
                n = m_fixed ? $urandom_range(1, 3) : $urandom_range(1, DIGITS - p);
                txn_q.push_back(8'hC0 | 8'(p));
                for (int i = 0; i < n; i++) txn_q.push_back(8'($urandom_range(0, 255)));
            end else begin
                txn_q.push_back(8'h80 | 8'($urandom_range(0, 15)));
            end
            run_txn();
            n_cmp += 4;
            if (digits !== m_digits()) begin n_err++; $display("FAIL rand_digits[%0d]: got %h, expected %h", it, digits, m_digits()); end
            if (display_on !== m_on) begin n_err++; $display("FAIL rand_display_on[%0d]: got %b, expected %b", it, display_on, m_on); end
            if (brightness !== m_bright) begin n_err++; $display("FAIL rand_brightness[%0d]: got %0d, expected %0d", it, brightness, m_bright); end
            if (cmd_error !== m_err) begin n_err++; $display("FAIL rand_cmd_error[%0d]: got %b, expected %b", it, cmd_error, m_err); end
        end
    endtask

    task automatic test_overflow();
        txn_q = '{8'h40}; run_txn();
        txn_q = '{8'hC4, 8'h11, 8'h22, 8'h33}; run_txn();
        n_cmp += 3;
        if (digits !== m_digits()) begin n_err++; $display("FAIL ovf_digits: got %h, expected %h", digits, m_digits()); end
        if (digits[47:32] !== 16'h2211) begin n_err++; $display("FAIL ovf_digit45: got %h, expected 2211", digits[47:32]); end
        if (cmd_error !== 1'b1) begin n_err++; $display("FAIL ovf_cmd_error: got %b, expected 1", cmd_error); end
    endtask

    task automatic test_partial_byte();
        txn_q = '{8'hC1, 8'h77}; run_txn();
        txn_q = '{8'hC2};
        model_txn();
        bus_start();
        send_byte(8'hC2, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bus_stop();
        txn_q.delete();
        n_cmp += 3;
        if (digits !== m_digits()) begin n_err++; $display("FAIL partial_digits: got %h, expected %h", digits, m_digits()); end
        if (sda_en !== 1'b0) begin n_err++; $display("FAIL partial_sda_en: got %b, expected 0", sda_en); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL partial_pulses: %0d pending, expected 0", exp_q.size()); end
        txn_q = '{8'hC2, 8'h5A}; run_txn();
        n_cmp++;
        if (digits !== m_digits()) begin n_err++; $display("FAIL partial_next_digits: got %h, expected %h", digits, m_digits()); end
    endtask

    task automatic test_reset_during_ack();
        logic [7:0] b;
        int budget;
        b = 8'hC3;
        exp_q.push_back(b);
        bus_start();
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        scl = 0;
        budget = 0;
        while (sda_en !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
        n_cmp++;
        if (sda_en !== 1'b1) begin n_err++; $display("FAIL rst_ack_wait: sda_en=%b, expected 1 within 50 clks", sda_en); end
        rst = 1; @(negedge clk); rst = 0;
        n_cmp += 4;
        if (sda_en !== 1'b0)  begin n_err++; $display("FAIL rst_ack_sda_en: got %b, expected 0", sda_en); end
        if (digits !== '0)    begin n_err++; $display("FAIL rst_ack_digits: got %h, expected 0", digits); end
        if (byte_data !== 0)  begin n_err++; $display("FAIL rst_ack_byte_data: got %h, expected 0", byte_data); end
        if (cmd_error !== 0)  begin n_err++; $display("FAIL rst_ack_cmd_error: got %b, expected 0", cmd_error); end
        model_reset();
        sda_m = 1; wait_h();
        scl = 1; wait_h(); wait_h();
        send_byte(8'hC0, 1'b0);
        send_byte(8'h4F, 1'b0);
        bus_stop();
        n_cmp += 2;
        if (digits !== '0) begin n_err++; $display("FAIL nostart_digits: got %h, expected 0", digits); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL nostart_pulses: %0d pending, expected 0", exp_q.size()); end
        txn_q = '{8'hC0, 8'h4F}; run_txn();
        n_cmp++;
        if (digits !== m_digits()) begin n_err++; $display("FAIL after_rst_digits: got %h, expected %h", digits, m_digits()); end
    endtask

    task automatic test_errors();
        do_reset();
        txn_q = '{8'h46}; run_txn();
        n_cmp++;
        if (cmd_error !== 1'b1) begin n_err++; $display("FAIL keyread_cmd_error: got %b, expected 1", cmd_error); end
        txn_q = '{8'hC0, 8'hAA, 8'hBB}; run_txn();
        n_cmp++;
        if (digits !== m_digits()) begin n_err++; $display("FAIL keyread_fixed_digits: got %h, expected %h", digits, m_digits()); end
        do_reset();
        txn_q = '{8'h8A, 8'h12}; run_txn();
        n_cmp += 4;
        if (cmd_error !== 1'b0) begin n_err++; $display("FAIL disp_trail_cmd_error: got %b, expected 0", cmd_error); end
        if (brightness !== 3'd2) begin n_err++; $display("FAIL disp_trail_bright: got %0d, expected 2", brightness); end
        if (display_on !== 1'b1) begin n_err++; $display("FAIL disp_trail_on: got %b, expected 1", display_on); end
        if (digits !== '0) begin n_err++; $display("FAIL disp_trail_digits: got %h, expected 0", digits); end
        txn_q = '{8'h00}; run_txn();
        n_cmp++;
        if (cmd_error !== 1'b1) begin n_err++; $display("FAIL cmd00_cmd_error: got %b, expected 1", cmd_error); end
    endtask

    initial begin
        rst = 1; scl = 1; sda_m = 1;
        model_reset();
        test_reset();
        test_auto_write();
        test_display_ctrl();
        test_fixed_mode();
        test_random();
        test_overflow();
        test_reset();
        test_partial_byte();
        test_reset_during_ack();
        test_errors();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL final_pulses: %0d bytes never reported, expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tm1637_responder.md
Name: tm1637_responder

Overview:
- Synthesizable two-wire (CLK/DIO) responder that models the TM1637 display-controller end of the link our tm1637 driver initiates.
- Detects start/stop, shifts bytes in LSB-first and ACKs each byte by pulling DIO low.
- Decodes data, address and display-control commands into a digit register file plus brightness/on state.
- Used for on-chip loopback against the driver and as a self-checking bench target.

Parameters:
DIGITS, 6, number of digit registers (valid addresses 0..DIGITS-1, max 8)
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
scl_in  in  1  CLK line as seen at the pad
sda_in  in  1  DIO line as seen at the pad
sda_en  out  1  1 = drive DIO (open-drain pull-low)
sda_out  out  1  value driven when sda_en=1; constant 0
digits  out  8*DIGITS  digit registers; digit n = bits [8n+7:8n]
display_on  out  1  display-control bit 3
brightness  out  3  display-control bits 2:0
byte_valid  out  1  one-clk pulse per received byte
byte_data  out  8  last received byte; held until the next byte
cmd_error  out  1  sticky; set on unsupported command or out-of-range address; cleared by reset only

Behaviour:
- Reset (rst=1 at posedge clk) clears all outputs, the state machine and internal mode/address to 0. After reset, write mode is auto-increment and the address pointer is 0.
- Inputs pass through SYNC_STAGES flops. Edges are detected on synchronized values. All timing below is in synchronized samples.
- Start: sda falls while scl=1. Stop: sda rises while scl=1. Both are honoured in every state.
  - Start resets the bit count and byte index and enters RX.
  - Stop releases sda_en and enters IDLE.
  - A partial byte at start/stop is discarded: no byte_valid, no register change.
- FSM states:
  - IDLE: wait for start.
  - RX: on each scl rising edge, shift sda in at bit[count], LSB first.
    - After the 8th rising edge, byte_data updates and byte_valid pulses on the next clk.
    - Command decode takes effect on that same cycle.
    - Go to ACK_WAIT.
  - ACK_WAIT: on the scl falling edge, assert sda_en=1 and go to ACK_HOLD.
  - ACK_HOLD: hold sda_en through the 9th clock. On the 9th scl falling edge, deassert sda_en, clear count, increment byte index (saturating at 15) and return to RX.
- Every complete byte is ACKed, including ignored or erroneous ones.
- Decode, first byte of a transaction (byte index 0) on bits[7:6]:
  - 01, data command:
    - bit2: 0 = auto-increment, 1 = fixed address.
    - bits1:0 must be 00. Otherwise (key read) set cmd_error; the mode is still latched.
    - Later bytes in this transaction are ignored.
  - 11, address command: pointer = bits[2:0]. Later bytes in this transaction are data bytes.
  - 10, display control: display_on = bit3, brightness = bits[2:0].
  - 00: set cmd_error; ignore.
- Data byte (index >= 1 after an address command):
  - If pointer < DIGITS, write to digits[pointer]. Otherwise discard and set cmd_error.
  - In auto mode, pointer increments after each data byte and saturates at 7 (no wrap). In fixed mode, the pointer is unchanged.
- Mode and pointer persist across transactions until overwritten or reset.
- Reset mid-transaction: state returns to IDLE and sda_en drops on the next clk. A subsequent start is required before further bytes are accepted.
- Start and stop in the same sample is impossible (single sda edge). A scl edge coincident with an sda change resolves as a data transition, not start/stop.

Test Plan:
- Driver sends 0x40+stop, then 0xC0,0x06,0x5B,0x4F,0x66+stop.
  -> digits[0..3]=06,5B,4F,66; digits[4..5]=00.
  -> 6 byte_valid pulses; 6 ACKs, each sda_en=1 exactly across the 9th clock; cmd_error=0.
- 0x8F+stop -> display_on=1, brightness=7. Then 0x80+stop -> display_on=0, brightness=0.
- 0x44+stop, then 0xC5,0x3F,0x06+stop.
  -> fixed mode; digits[5]=06 (0x3F overwritten); digits[0..4] unchanged.
- 0x40; 0xC4,0x11,0x22,0x33+stop.
  -> digits[4]=11, digits[5]=22; 0x33 discarded; cmd_error=1. After rst: all outputs 0.
- Stop after 5 bits of a data byte.
  -> no byte_valid, digits unchanged, sda_en=0. Next full transaction is accepted normally.
- rst pulsed while sda_en=1 during an ACK.
  -> sda_en=0 and all registers 0 the next clk. Bytes without a preceding start are ignored.
